// File: rtl/cdb_arbiter.sv
// cdb_arbiter: three-way arbiter onto a single registered common data bus.
// Requester 0 = ALU, 1 = LSB, 2 = JUMP. Grants are combinational; the
// broadcast is registered, so a transfer at edge N is on cdb_* until N+1.
// Build option: define CDB_RR_EN for rotating priority; otherwise fixed
// priority 0 > 1 > 2 with no pointer state.
module cdb_arbiter #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic                   rdy_in,
    input  logic                   rollback_in,
    input  logic [2:0]             req_valid_in,
    input  logic [2:0][TAG_W-1:0]  req_tag_in,
    input  logic [2:0][DATA_W-1:0] req_data_in,
    output logic [2:0]             req_ready_out,
    output logic                   cdb_valid_out,
    output logic [TAG_W-1:0]       cdb_tag_out,
    output logic [DATA_W-1:0]      cdb_data_out,
    output logic [1:0]             cdb_src_out,
    output logic [15:0]            conflict_cnt_out
);

    // (a + b) mod 3 for operands already in 0..2
    function automatic logic [1:0] add_mod3(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 3'd3) s = s - 3'd3;
        return s[1:0];
    endfunction

    logic [1:0] base;      // requester that currently has top priority
    logic [1:0] win_idx;
    logic       win_hit;
    logic       grant_en;
    logic       any_grant;
    logic       conflict;

`ifdef CDB_RR_EN
    logic [1:0] ptr;
    assign base = ptr;
`else
    assign base = 2'd0;
`endif

    // grants are suppressed during reset, pause and flush
    assign grant_en = rst_n_in & rdy_in & ~rollback_in;

    // walk offsets 2..0 so the lowest offset from base is the final winner
    always_comb begin
        win_hit = 1'b0;
        win_idx = 2'd0;
        for (int j = 2; j >= 0; j--) begin
            if (req_valid_in[add_mod3(base, 2'(j))]) begin
                win_hit = 1'b1;
                win_idx = add_mod3(base, 2'(j));
            end
        end
    end

    // one-hot grant to the winner, or nothing
    always_comb begin
        req_ready_out = 3'b000;
        if (grant_en && win_hit) req_ready_out[win_idx] = 1'b1;
    end

    assign any_grant = |req_ready_out;
    assign conflict  = |(req_valid_in & ~req_ready_out);

    // broadcast register and saturating conflict counter
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cdb_valid_out    <= 1'b0;
            cdb_tag_out      <= '0;
            cdb_data_out     <= '0;
            cdb_src_out      <= 2'd0;
            conflict_cnt_out <= 16'd0;
        end else if (rdy_in) begin
            if (rollback_in) begin
                cdb_valid_out <= 1'b0;
            end else begin
                cdb_valid_out <= any_grant;
                if (any_grant) begin
                    cdb_tag_out  <= req_tag_in[win_idx];
                    cdb_data_out <= req_data_in[win_idx];
                    cdb_src_out  <= win_idx;
                end
                if (conflict && conflict_cnt_out != 16'hFFFF)
                    conflict_cnt_out <= conflict_cnt_out + 16'd1;
            end
        end
    end

`ifdef CDB_RR_EN
    // priority pointer moves just past the last winner; flush returns it to 0
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            ptr <= 2'd0;
        end else if (rdy_in) begin
            if (rollback_in)    ptr <= 2'd0;
            else if (any_grant) ptr <= add_mod3(win_idx, 2'd1);
        end
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed and randomized checks of cdb_arbiter against a
// behavioural model of the grant rules, broadcast register and counter.
module tb_cdb_arbiter;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 4;

    logic                   clk_in = 1'b0;
    logic                   rst_n_in;
    logic                   rdy_in;
    logic                   rollback_in;
    logic [2:0]             req_valid_in;
    logic [2:0][TAG_W-1:0]  req_tag_in;
    logic [2:0][DATA_W-1:0] req_data_in;
    logic [2:0]             req_ready_out;
    logic                   cdb_valid_out;
    logic [TAG_W-1:0]       cdb_tag_out;
    logic [DATA_W-1:0]      cdb_data_out;
    logic [1:0]             cdb_src_out;
    logic [15:0]            conflict_cnt_out;

    cdb_arbiter #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .rollback_in(rollback_in),
        .req_valid_in(req_valid_in), .req_tag_in(req_tag_in), .req_data_in(req_data_in),
        .req_ready_out(req_ready_out), .cdb_valid_out(cdb_valid_out), .cdb_tag_out(cdb_tag_out),
        .cdb_data_out(cdb_data_out), .cdb_src_out(cdb_src_out), .conflict_cnt_out(conflict_cnt_out)
    );

    always #5 clk_in = ~clk_in;

    int n_pass = 0;
    int n_total = 0;

    // reference model state
    int               m_ptr;
    logic [15:0]      m_cnt;
    logic             m_valid;
    logic [TAG_W-1:0] m_tag;
    logic [DATA_W-1:0] m_data;
    logic [1:0]       m_src;
    logic [2:0]       m_gnt;
    logic [2:0]       obs_gnt;

    // first valid requester scanning p, p+1, p+2 modulo 3; -1 when none
    function automatic int pick(input logic [2:0] v, input int p);
        for (int off = 0; off < 3; off++)
            if (v[(p + off) % 3]) return (p + off) % 3;
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_cnt = 16'd0; m_valid = 1'b0; m_tag = '0; m_data = '0; m_src = 2'd0;
    endtask

    // one clock: apply inputs, sample grant mid-cycle, advance model, return at edge+1
    task automatic tick(input logic [2:0] v, input bit rdy, input bit rb);
        int w;
        req_valid_in = v; rdy_in = rdy; rollback_in = rb;
        #1;
        obs_gnt = req_ready_out;
        w = pick(v, m_ptr);
        m_gnt = (rdy && !rb && w >= 0) ? 3'(1 << w) : 3'b000;
        @(posedge clk_in);
        if (rdy) begin
            if (rb) begin
                m_valid = 1'b0;
                m_ptr = 0;
            end else begin
                m_valid = (w >= 0);
                if (w >= 0) begin
                    m_tag = req_tag_in[w]; m_data = req_data_in[w]; m_src = 2'(w);
`ifdef CDB_RR_EN
                    m_ptr = (w + 1) % 3;
`endif
                end
                if ((v & ~m_gnt) != 3'b000 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
        end
        #1;
    endtask

    task automatic apply_reset();
        rst_n_in = 1'b0; req_valid_in = 3'b000; rdy_in = 1'b1; rollback_in = 1'b0;
        @(posedge clk_in); #3;
        rst_n_in = 1'b1;
        model_reset();
        @(posedge clk_in); #1;
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0; req_valid_in = 3'b111; rdy_in = 1'b1; rollback_in = 1'b0;
        req_tag_in = '1; req_data_in = '1;
        repeat (2) @(posedge clk_in);
        #1;
        n_total++;
        if (req_ready_out !== 3'b000) $display("FAIL reset_ready got %b want 000", req_ready_out);
        else n_pass++;
        n_total++;
        if ({cdb_valid_out, cdb_tag_out, cdb_data_out, cdb_src_out, conflict_cnt_out} !== '0)
            $display("FAIL reset_outputs got v=%b t=%h d=%h s=%0d c=%h want all 0",
                     cdb_valid_out, cdb_tag_out, cdb_data_out, cdb_src_out, conflict_cnt_out);
        else n_pass++;
        apply_reset();
    endtask

    task automatic test_basic();
        apply_reset();
        req_tag_in[0] = 4'd3; req_data_in[0] = 32'h1234;
        tick(3'b001, 1'b1, 1'b0);
        n_total++;
        if (obs_gnt !== 3'b001) $display("FAIL basic_grant got %b want 001", obs_gnt);
        else n_pass++;
        n_total++;
        if ({cdb_valid_out, cdb_tag_out, cdb_data_out, cdb_src_out} !== {1'b1, 4'd3, 32'h1234, 2'd0})
            $display("FAIL basic_bcast got v=%b t=%h d=%h s=%0d want v=1 t=3 d=1234 s=0",
                     cdb_valid_out, cdb_tag_out, cdb_data_out, cdb_src_out);
        else n_pass++;
        tick(3'b000, 1'b1, 1'b0);
        n_total++;
        if (cdb_valid_out !== 1'b0 || cdb_tag_out !== 4'd3 || cdb_data_out !== 32'h1234)
            $display("FAIL basic_idle got v=%b t=%h d=%h want v=0 t=3 d=1234",
                     cdb_valid_out, cdb_tag_out, cdb_data_out);
        else n_pass++;
    endtask

    task automatic test_contention();
        logic [2:0] exp;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            req_tag_in[i % 3] = TAG_W'(i); req_data_in[i % 3] = 32'(i * 7);
            tick(3'b111, 1'b1, 1'b0);
`ifdef CDB_RR_EN
            exp = 3'(1 << (i % 3));
`else
            exp = 3'b001;
`endif
            n_total++;
            if (obs_gnt !== exp) $display("FAIL contend_grant[%0d] got %b want %b", i, obs_gnt, exp);
            else n_pass++;
        end
        n_total++;
        if (conflict_cnt_out !== 16'd6) $display("FAIL contend_cnt got %0d want 6", conflict_cnt_out);
        else n_pass++;
    endtask

    task automatic test_rollback();
        apply_reset();
        tick(3'b111, 1'b1, 1'b0);
        tick(3'b010, 1'b1, 1'b1);
        n_total++;
        if (obs_gnt !== 3'b000) $display("FAIL rollback_grant got %b want 000", obs_gnt);
        else n_pass++;
        n_total++;
        if (cdb_valid_out !== 1'b0 || conflict_cnt_out !== 16'd1)
            $display("FAIL rollback_state got v=%b c=%0d want v=0 c=1", cdb_valid_out, conflict_cnt_out);
        else n_pass++;
        tick(3'b111, 1'b1, 1'b0);
        n_total++;
        if (obs_gnt !== 3'b001) $display("FAIL rollback_ptr got %b want 001", obs_gnt);
        else n_pass++;
    endtask

    task automatic test_pause();
        apply_reset();
        req_tag_in[0] = 4'd5; req_data_in[0] = 32'hABCD;
        req_tag_in[2] = 4'd9; req_data_in[2] = 32'h5A5A;
        tick(3'b001, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(3'b100, 1'b0, 1'b0);
            n_total++;
            if (obs_gnt !== 3'b000) $display("FAIL pause_grant[%0d] got %b want 000", i, obs_gnt);
            else n_pass++;
            n_total++;
            if ({cdb_valid_out, cdb_tag_out, cdb_data_out, cdb_src_out, conflict_cnt_out} !==
                {1'b1, 4'd5, 32'hABCD, 2'd0, 16'd0})
                $display("FAIL pause_hold[%0d] got v=%b t=%h d=%h s=%0d c=%0d want v=1 t=5 d=abcd s=0 c=0",
                         i, cdb_valid_out, cdb_tag_out, cdb_data_out, cdb_src_out, conflict_cnt_out);
            else n_pass++;
        end
        tick(3'b100, 1'b1, 1'b0);
        n_total++;
        if (obs_gnt !== 3'b100 || cdb_valid_out !== 1'b1 || cdb_src_out !== 2'd2 || cdb_tag_out !== 4'd9)
            $display("FAIL pause_resume got g=%b v=%b s=%0d t=%h want g=100 v=1 s=2 t=9",
                     obs_gnt, cdb_valid_out, cdb_src_out, cdb_tag_out);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [2:0] v;
        logic [2:0] pend;
        bit rdy, rb;
        apply_reset();
        v = 3'b000; pend = 3'b000;
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 3; k++) begin
                if (!pend[k]) begin
                    v[k] = ($urandom_range(0, 2) != 0);
                    req_tag_in[k] = TAG_W'($urandom);
                    req_data_in[k] = $urandom;
                end
            end
            rdy = ($urandom_range(0, 7) != 0);
            rb  = ($urandom_range(0, 15) == 0);
            tick(v, rdy, rb);
            n_total++;
            if (obs_gnt !== m_gnt || cdb_valid_out !== m_valid || cdb_tag_out !== m_tag ||
                cdb_data_out !== m_data || cdb_src_out !== m_src || conflict_cnt_out !== m_cnt)
                $display("FAIL random[%0d] got g=%b v=%b t=%h d=%h s=%0d c=%0d want g=%b v=%b t=%h d=%h s=%0d c=%0d",
                         n, obs_gnt, cdb_valid_out, cdb_tag_out, cdb_data_out, cdb_src_out, conflict_cnt_out,
                         m_gnt, m_valid, m_tag, m_data, m_src, m_cnt);
            else n_pass++;
            pend = v & ~m_gnt;
        end
    endtask

    task automatic test_saturate();
        apply_reset();
        req_valid_in = 3'b111; rdy_in = 1'b1; rollback_in = 1'b0;
        repeat (65534) @(posedge clk_in);
        #1;
        n_total++;
        if (conflict_cnt_out !== 16'hFFFE) $display("FAIL sat_preload got %h want fffe", conflict_cnt_out);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick(3'b111, 1'b1, 1'b0);
            n_total++;
            if (conflict_cnt_out !== 16'hFFFF) $display("FAIL sat_hold[%0d] got %h want ffff", i, conflict_cnt_out);
            else n_pass++;
        end
        // reset pulsed mid-cycle while a transfer is being offered
        #2 rst_n_in = 1'b0;
        #1;
        n_total++;
        if ({cdb_valid_out, cdb_tag_out, cdb_data_out, cdb_src_out, conflict_cnt_out} !== '0 ||
            req_ready_out !== 3'b000)
            $display("FAIL async_reset got v=%b t=%h d=%h s=%0d c=%h g=%b want all 0",
                     cdb_valid_out, cdb_tag_out, cdb_data_out, cdb_src_out, conflict_cnt_out, req_ready_out);
        else n_pass++;
        @(posedge clk_in); #3;
        req_valid_in = 3'b000;
        rst_n_in = 1'b1;
        model_reset();
        @(posedge clk_in); #1;
        tick(3'b000, 1'b1, 1'b0);
        n_total++;
        if (cdb_valid_out !== 1'b0) $display("FAIL post_reset_bcast got v=%b want 0", cdb_valid_out);
        else n_pass++;
    endtask

    initial begin
        rst_n_in = 1'b0; rdy_in = 1'b0; rollback_in = 1'b0;
        req_valid_in = 3'b000; req_tag_in = '0; req_data_in = '0;
        model_reset();
        m_gnt = 3'b000; obs_gnt = 3'b000;
        test_reset();
        test_basic();
        test_contention();
        test_rollback();
        test_pause();
        test_random();
        test_saturate();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
